ibex_ahb_bridge: RTL and testbench

Bridge between the ibex core's two request/grant/rvalid memory ports (instruction and data) and the single AHB master port of ibex_AHB_master.
- Round-robin arbitration between the two ports.
- One transfer in flight at a time; all transfers are SINGLE NONSEQ.
- Ibex byte-enables are translated to HSIZE/HADDR[1:0], and AHB responses are returned as rvalid/err.

---
 rtl/ibex_ahb_pkg.sv | 51 +++++
 rtl/ibex_ahb_rr_arb.sv | 29 ++
 rtl/ibex_ahb_bridge.sv | 161 ++++++++++++++++
 tb/tb_ibex_ahb_bridge.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_ahb_pkg.sv
// AHB encodings, bridge FSM states and the captured-transfer record used by ibex_ahb_bridge.
// Also holds the byte-enable to HSIZE/HADDR[1:0] translation.
package ibex_ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;
   localparam logic [1:0] HRESP_RETRY = 2'b10;
   localparam logic [1:0] HRESP_SPLIT = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   typedef enum logic [1:0] {IDLE, BREQ, ADDR, DATA} bridge_state_e;

   typedef struct packed {
      logic        is_data;
      logic [29:0] addr_hi;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } xfer_t;

   typedef struct packed {
      logic [2:0] hsize;
      logic [1:0] lsb;
   } size_lsb_t;

   // Unsupported lane patterns fall back to a full-word access at offset 0.
   function automatic size_lsb_t be_to_size(input logic [3:0] be);
      size_lsb_t s;
      s.hsize = HSIZE_WORD;
      s.lsb   = 2'b00;
      case (be)
         4'b0011: s = '{hsize: HSIZE_HALF, lsb: 2'b00};
         4'b1100: s = '{hsize: HSIZE_HALF, lsb: 2'b10};
         4'b0001: s = '{hsize: HSIZE_BYTE, lsb: 2'b00};
         4'b0010: s = '{hsize: HSIZE_BYTE, lsb: 2'b01};
         4'b0100: s = '{hsize: HSIZE_BYTE, lsb: 2'b10};
         4'b1000: s = '{hsize: HSIZE_BYTE, lsb: 2'b11};
         default: s = '{hsize: HSIZE_WORD, lsb: 2'b00};
      endcase
      return s;
   endfunction

endpackage

// File: rtl/ibex_ahb_rr_arb.sv
// Two-way round-robin arbiter (bit 0 = instr, bit 1 = data): combinational grant while en_i,
// registered last winner so the other port wins the next tie.
module ibex_ahb_rr_arb (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   logic rr_last_q, rr_last_d;

   always_comb begin
      gnt_o = 2'b00;
      if (en_i) begin
         if (req_i == 2'b11) gnt_o = rr_last_q ? 2'b01 : 2'b10;
         else                gnt_o = req_i;
      end
      rr_last_d = rr_last_q;
      if (gnt_o[1])      rr_last_d = 1'b1;
      else if (gnt_o[0]) rr_last_d = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) rr_last_q <= 1'b0;
      else       rr_last_q <= rr_last_d;
   end

endmodule

// File: rtl/ibex_ahb_bridge.sv
// Ibex instr/data ports to one AHB master: one SINGLE NONSEQ at a time, gnt in cycle 0, rvalid >= cycle 3.
// Ports stall (no gnt) until the bus transfer completes; IBEX_AHB_RETRY_EN reissues on RETRY/SPLIT.
module ibex_ahb_bridge
   import ibex_ahb_pkg::*;
#(
   parameter logic       HPROT_PRIV = 1'b1,
   parameter logic [3:0] RETRY_MAX  = 4'd15
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        instr_req_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   input  logic [31:0] instr_addr_i,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   input  logic        data_req_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   input  logic        HGRANT_x,
   input  logic        HREADY,
   input  logic [1:0]  HRESP,
   input  logic [31:0] HRDATA,
   output logic        HBUSREQ_x,
   output logic        HLOCK_x,
   output logic [1:0]  HTRANS,
   output logic [31:0] HADDR,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [3:0]  HPROT,
   output logic [31:0] HWDATA
);

   bridge_state_e state_q, state_d;
   xfer_t         xfer_q, xfer_d;
   size_lsb_t     sz;
   logic [1:0]    gnt;
   logic          done, err;

`ifdef IBEX_AHB_RETRY_EN
   logic [3:0] retry_cnt_q, retry_cnt_d;
`else
   logic unused_retry_max;
   assign unused_retry_max = ^RETRY_MAX;
`endif

   logic unused_addr_lsb;
   assign unused_addr_lsb = ^{instr_addr_i[1:0], data_addr_i[1:0]};

   ibex_ahb_rr_arb u_arb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  ((state_q == IDLE) && !rst_i),
      .req_i ({data_req_i, instr_req_i}),
      .gnt_o (gnt)
   );

   assign instr_gnt_o = gnt[0];
   assign data_gnt_o  = gnt[1];
   assign HLOCK_x     = 1'b0;
   assign HBURST      = HBURST_SINGLE;

   always_comb begin
      state_d   = state_q;
      xfer_d    = xfer_q;
      sz        = be_to_size(xfer_q.be);
      done      = 1'b0;
      err       = 1'b0;
      HBUSREQ_x = 1'b0;
      HTRANS    = HTRANS_IDLE;
      HADDR     = '0;
      HWRITE    = 1'b0;
      HSIZE     = '0;
      HPROT     = '0;
      HWDATA    = '0;
`ifdef IBEX_AHB_RETRY_EN
      retry_cnt_d = retry_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (gnt != 2'b00) begin
               // Instruction fetches are captured as plain word reads.
               xfer_d.is_data = gnt[1];
               xfer_d.addr_hi = gnt[1] ? data_addr_i[31:2] : instr_addr_i[31:2];
               xfer_d.we      = gnt[1] & data_we_i;
               xfer_d.be      = gnt[1] ? data_be_i : 4'b1111;
               xfer_d.wdata   = gnt[1] ? data_wdata_i : '0;
               state_d        = BREQ;
`ifdef IBEX_AHB_RETRY_EN
               retry_cnt_d    = '0;
`endif
            end
         end
         BREQ: begin
            HBUSREQ_x = 1'b1;
            if (HGRANT_x && HREADY) state_d = ADDR;
         end
         ADDR: begin
            HBUSREQ_x = 1'b1;
            HTRANS    = HTRANS_NONSEQ;
            HADDR     = {xfer_q.addr_hi, sz.lsb};
            HWRITE    = xfer_q.we;
            HSIZE     = sz.hsize;
            HPROT     = {2'b00, HPROT_PRIV, xfer_q.is_data};
            if (!HGRANT_x)   state_d = BREQ;
            else if (HREADY) state_d = DATA;
         end
         DATA: begin
            HWDATA = xfer_q.wdata;
            if (HREADY) begin
               done = 1'b1;
               err  = (HRESP != HRESP_OKAY);
`ifdef IBEX_AHB_RETRY_EN
               if (HRESP[1] && (retry_cnt_q != RETRY_MAX)) begin
                  done        = 1'b0;
                  err         = 1'b0;
                  retry_cnt_d = retry_cnt_q + 4'd1;
                  state_d     = BREQ;
               end
`endif
               if (done) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Responses are suppressed while reset is held so an interrupted transfer never completes.
   always_comb begin
      instr_rvalid_o = done && !rst_i && !xfer_q.is_data;
      data_rvalid_o  = done && !rst_i &&  xfer_q.is_data;
      instr_err_o    = instr_rvalid_o && err;
      data_err_o     = data_rvalid_o && err;
      instr_rdata_o  = (instr_rvalid_o && !err) ? HRDATA : '0;
      data_rdata_o   = (data_rvalid_o && !err && !xfer_q.we) ? HRDATA : '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         xfer_q      <= '0;
`ifdef IBEX_AHB_RETRY_EN
         retry_cnt_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         xfer_q      <= xfer_d;
`ifdef IBEX_AHB_RETRY_EN
         retry_cnt_q <= retry_cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_ibex_ahb_bridge.sv
// Directed plus randomized checks of ibex_ahb_bridge against a transaction-level model of the bridge rules.
module tb_ibex_ahb_bridge;

`ifdef IBEX_AHB_RETRY_EN
   localparam bit RETRY_EN = 1'b1;
`else
   localparam bit RETRY_EN = 1'b0;
`endif
   localparam int RMAX = 15;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
   logic [31:0] instr_addr_i, instr_rdata_o;
   logic        data_req_i, data_gnt_o, data_rvalid_o, data_we_i, data_err_o;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
   logic        HGRANT_x, HREADY, HBUSREQ_x, HLOCK_x, HWRITE;
   logic [1:0]  HRESP, HTRANS;
   logic [31:0] HRDATA, HADDR, HWDATA;
   logic [2:0]  HSIZE, HBURST;
   logic [3:0]  HPROT;

   int n_cmp = 0;
   int n_err = 0;
   bit last_port;

   always #5 clk_i = ~clk_i;

   ibex_ahb_bridge #(.HPROT_PRIV(1'b1), .RETRY_MAX(4'd15)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
      .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
      .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
      .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
      .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
      .HGRANT_x(HGRANT_x), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
      .HBUSREQ_x(HBUSREQ_x), .HLOCK_x(HLOCK_x), .HTRANS(HTRANS), .HADDR(HADDR),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Reference rules: one lane -> byte at that lane; an aligned lower/upper pair -> halfword; else word.
   function automatic logic [2:0] exp_size(input bit is_data, input logic [3:0] be);
      if (!is_data) return 3'd2;
      if ($countones(be) == 1) return 3'd0;
      if (be == 4'b0011 || be == 4'b1100) return 3'd1;
      return 3'd2;
   endfunction

   function automatic logic [1:0] exp_lsb(input bit is_data, input logic [3:0] be);
      if (!is_data) return 2'd0;
      if ($countones(be) == 1)
         for (int i = 0; i < 4; i++) if (be[i]) return i[1:0];
      if (be == 4'b1100) return 2'd2;
      return 2'd0;
   endfunction

   task automatic bus_grant(input int gwait);
      for (int i = 0; i < gwait; i++) begin
         HGRANT_x = 1'b0;
         #1;
         chk("breq_wait_busreq", HBUSREQ_x, 1);
         chk("breq_wait_htrans", HTRANS, 2'b00);
         chk("breq_wait_rvalid", {instr_rvalid_o, data_rvalid_o}, 2'b00);
         step();
      end
      HGRANT_x = 1'b1;
      HREADY   = 1'b1;
      #1;
      chk("breq_busreq", HBUSREQ_x, 1);
      chk("breq_htrans", HTRANS, 2'b00);
      step();
   endtask

   task automatic addr_phase(input bit port, input bit we, input logic [31:0] haddr,
                             input logic [2:0] hsz, input bit drop);
      if (drop) begin
         HGRANT_x = 1'b0;
         #1;
         chk("drop_htrans", HTRANS, 2'b10);
         step();
         bus_grant(0);
      end
      HGRANT_x = 1'b1;
      HREADY   = 1'b1;
      #1;
      chk("addr_htrans", HTRANS, 2'b10);
      chk("addr_haddr", HADDR, haddr);
      chk("addr_hsize", HSIZE, hsz);
      chk("addr_hwrite", HWRITE, port & we);
      chk("addr_hprot", HPROT, {2'b00, 1'b1, port});
      chk("addr_busreq", HBUSREQ_x, 1);
      chk("addr_hburst_hlock", {HBURST, HLOCK_x}, 4'b0000);
      step();
   endtask

   // One complete transfer: nretry RETRY/SPLIT responses followed by OKAY or ERROR (fin_err).
   task automatic xfer(input bit port, input logic [31:0] addr, input bit we, input logic [3:0] be,
                       input logic [31:0] wdata, input logic [31:0] rdata, input int gwait,
                       input bit drop, input bit slow, input int nretry, input bit fin_err);
      logic [31:0] haddr;
      logic [2:0]  hsz;
      logic [1:0]  resp;
      bit          last;
      haddr = {addr[31:2], exp_lsb(port, be)};
      hsz   = exp_size(port, be);
      instr_req_i  = !port;
      data_req_i   = port;
      instr_addr_i = addr;
      data_addr_i  = addr;
      data_we_i    = we;
      data_be_i    = be;
      data_wdata_i = wdata;
      HGRANT_x = 1'b0;
      HREADY   = 1'b1;
      HRESP    = 2'b00;
      #1;
      chk("gnt_cycle0", {instr_gnt_o, data_gnt_o}, port ? 2'b01 : 2'b10);
      chk("idle_busreq", HBUSREQ_x, 0);
      step();
      last_port    = port;
      instr_req_i  = 1'b0;
      data_req_i   = 1'b0;
      data_we_i    = ~we;
      data_be_i    = ~be;
      data_addr_i  = ~addr;
      instr_addr_i = ~addr;
      data_wdata_i = ~wdata;
      bus_grant(gwait);
      for (int k = 0; k <= nretry; k++) begin
         addr_phase(port, we, haddr, hsz, drop);
         resp = (k < nretry) ? (2'b10 | 2'($urandom_range(0, 1))) : (fin_err ? 2'b01 : 2'b00);
         last = !((k < nretry) && RETRY_EN && (k < RMAX));
         if (slow) begin
            HREADY = 1'b0;
            HRESP  = resp;
            HRDATA = $urandom;
            #1;
            chk("wait_rvalid", {instr_rvalid_o, data_rvalid_o}, 2'b00);
            step();
         end
         HREADY = 1'b1;
         HRESP  = resp;
         HRDATA = rdata;
         #1;
         chk("data_htrans", HTRANS, 2'b00);
         chk("data_busreq", HBUSREQ_x, 0);
         if (port && we) chk("data_hwdata", HWDATA, wdata);
         chk("rvalid", {instr_rvalid_o, data_rvalid_o}, last ? (port ? 2'b01 : 2'b10) : 2'b00);
         if (last) begin
            chk("err", {instr_err_o, data_err_o},
                (resp != 2'b00) ? (port ? 2'b01 : 2'b10) : 2'b00);
            if (resp == 2'b00)
               chk("rdata", port ? data_rdata_o : instr_rdata_o, we ? 32'h0 : rdata);
         end
         step();
         HRESP = 2'b00;
         if (last) break;
         bus_grant(0);
      end
   endtask

   initial begin
      bit          p, w, ex;
      logic [31:0] a;
      logic [1:0]  exp_g;

      rst_i = 1'b1;
      instr_req_i = 1'b1; data_req_i = 1'b1;
      instr_addr_i = '0; data_addr_i = '0; data_we_i = 1'b0; data_be_i = 4'hF; data_wdata_i = '0;
      HGRANT_x = 1'b1; HREADY = 1'b1; HRESP = 2'b00; HRDATA = 32'h1234_5678;
      step(); step(); step();
      chk("rst_gnt", {instr_gnt_o, data_gnt_o}, 2'b00);
      chk("rst_rvalid_err", {instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o}, 4'b0000);
      chk("rst_bus", {HBUSREQ_x, HTRANS, HWRITE, HSIZE}, '0);
      chk("rst_haddr", HADDR, 32'h0);
      chk("rst_hwdata_hprot", {HWDATA, HPROT}, '0);
      instr_req_i = 1'b0; data_req_i = 1'b0;
      rst_i = 1'b0;
      last_port = 1'b0;
      step();

      xfer(1, 32'h100, 0, 4'b1111, 32'h0, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      xfer(1, 32'h203, 1, 4'b1000, 32'hAA000000, 32'h5555AAAA, 0, 0, 0, 0, 0);
      xfer(1, 32'h402, 1, 4'b1100, 32'h12340000, 32'h0, 0, 0, 1, 0, 0);
      xfer(1, 32'h500, 0, 4'b0110, 32'h0, 32'hCAFEF00D, 0, 0, 0, 0, 0);
      xfer(0, 32'h1000, 0, 4'b0001, 32'h0, 32'h00000013, 5, 0, 0, 0, 0);
      xfer(0, 32'h2000, 0, 4'b1111, 32'h0, 32'h0, 0, 0, 1, 0, 1);
      xfer(1, 32'h3000, 0, 4'b1111, 32'h0, 32'h0BADF00D, 0, 0, 0, 2, 0);
      xfer(1, 32'h3004, 0, 4'b1111, 32'h0, 32'h0, 0, 0, 0, RMAX + 1, 0);
      xfer(0, 32'h4000, 0, 4'b1111, 32'h0, 32'h87654321, 1, 1, 0, 0, 0);

      // Reset while a response is pending: nothing may complete.
      data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h40;
      HGRANT_x = 1'b1; HREADY = 1'b1; HRESP = 2'b00;
      #1;
      chk("mid_gnt", data_gnt_o, 1);
      step();
      data_req_i = 1'b0;
      step(); step();
      HREADY = 1'b0;
      step();
      rst_i = 1'b1; HREADY = 1'b1; HRDATA = 32'hFFFF0000;
      #1;
      chk("mid_rst_rvalid", {instr_rvalid_o, data_rvalid_o}, 2'b00);
      step();
      rst_i = 1'b0;
      last_port = 1'b0;
      #1;
      chk("post_rst_bus", {HBUSREQ_x, HTRANS}, 3'b000);

      // Both ports requesting continuously with an always-ready bus: one transfer per 4 cycles.
      instr_req_i = 1'b1; data_req_i = 1'b1; instr_addr_i = 32'h800;
      data_addr_i = 32'h900; data_we_i = 1'b0; data_be_i = 4'hF;
      HGRANT_x = 1'b1; HREADY = 1'b1; HRESP = 2'b00;
      for (int c = 0; c < 20; c++) begin
         HRDATA = $urandom;
         #1;
         exp_g = last_port ? 2'b10 : 2'b01;
         if (c % 4 == 0) chk("rr_gnt", {instr_gnt_o, data_gnt_o}, exp_g);
         else            chk("rr_no_gnt", {instr_gnt_o, data_gnt_o}, 2'b00);
         if (c % 4 == 3) chk("rr_rvalid", {instr_rvalid_o, data_rvalid_o}, last_port ? 2'b01 : 2'b10);
         if (c % 4 == 0) last_port = ~last_port;
         step();
      end
      instr_req_i = 1'b0; data_req_i = 1'b0;
      step(); step(); step(); step();

      for (int t = 0; t < 40; t++) begin
         p  = 1'($urandom_range(0, 1));
         w  = p & 1'($urandom_range(0, 1));
         a  = $urandom;
         if (!p) a[1:0] = 2'b00;
         ex = ($urandom_range(0, 3) == 0);
         xfer(p, a, w, 4'($urandom), $urandom, $urandom, $urandom_range(0, 3),
              ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0, ex);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
